bid_cmd_sequencer: RTL and testbench

BID_CMD_SEQUENCER -- requirements
Module: bid_cmd_sequencer

---
 rtl/bid_cmd_sequencer.sv | 104 ++++++++++
 tb/tb_bid_cmd_sequencer.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/bid_cmd_sequencer.sv
// bid_cmd_sequencer: queues host commands and issues them one at a time to a bid controller,
// reporting each completion (or timeout) with its result code.
module bid_cmd_sequencer #(
  parameter int DATAWIDTH = 32,
  parameter int DEPTH     = 4,
  parameter int TIMEOUT   = 255
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [3:0]              cmd_op,
  input  logic [DATAWIDTH-1:0]    cmd_data,
  output logic [3:0]              C_op,
  output logic [DATAWIDTH-1:0]    C_data,
  output logic                    C_start,
  input  logic                    ready,
  input  logic [2:0]              err,
  output logic                    done_valid,
  output logic [3:0]              done_op,
  output logic [2:0]              done_err,
  output logic                    busy,
  output logic [$clog2(DEPTH):0]  fifo_count,
  output logic [15:0]             err_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT + 1) + 1;
  localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  state_t               state;
  logic [DATAWIDTH+3:0] mem [DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [TW-1:0]        wcnt;
  logic [3:0]           op_q;
  logic                 avail, push, pop;
  assign cmd_ready = fifo_count < FULL;
  assign push      = cmd_valid && cmd_ready;
  assign pop       = state == ISSUE;
  assign busy      = state != IDLE || fifo_count != '0;
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= {cmd_op, cmd_data};
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      fifo_count <= fifo_count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  // avail lags fifo_count by one cycle, so a freshly written head is issued one edge later
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state      <= IDLE;
      avail      <= 1'b0;
      C_start    <= 1'b0;
      C_op       <= '0;
      C_data     <= '0;
      op_q       <= '0;
      wcnt       <= '0;
      done_valid <= 1'b0;
      done_op    <= '0;
      done_err   <= '0;
      err_count  <= '0;
    end else begin
      avail <= fifo_count != '0;
      unique case (state)
        IDLE:
          if (avail && ready) begin
            state             <= ISSUE;
            C_start           <= 1'b1;
            {C_op, C_data}    <= mem[rd_ptr];
          end
        ISSUE: begin
          state   <= WAIT;
          C_start <= 1'b0;
          C_op    <= '0;
          C_data  <= '0;
          op_q    <= C_op;
          wcnt    <= TW'(1);
        end
        WAIT:
          if (wcnt >= TW'(2) && ready) begin
            state      <= DONE;
            done_valid <= 1'b1;
            done_op    <= op_q;
            done_err   <= err;
          end else if (wcnt >= TW'(TIMEOUT)) begin
            state      <= DONE;
            done_valid <= 1'b1;
            done_op    <= op_q;
            done_err   <= 3'd7;
          end else begin
            wcnt <= wcnt + 1'b1;
          end
        DONE: begin
          state      <= IDLE;
          done_valid <= 1'b0;
          if (done_err != '0 && err_count != 16'hFFFF) err_count <= err_count + 16'd1;
        end
      endcase
    end
endmodule

// File: tb/tb_bid_cmd_sequencer.sv
// tb_bid_cmd_sequencer: directed checks of queueing, issue timing, completion, timeout and reset.
module tb_bid_cmd_sequencer;
  logic        clk, reset_n, cmd_valid, cmd_ready, C_start, ready, done_valid, busy;
  logic [3:0]  cmd_op, C_op, done_op;
  logic [31:0] cmd_data, C_data;
  logic [2:0]  err, done_err;
  logic [2:0]  fifo_count;
  logic [15:0] err_count;

  bid_cmd_sequencer #(.DATAWIDTH(32), .DEPTH(4), .TIMEOUT(8)) dut (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .C_op(C_op), .C_data(C_data), .C_start(C_start),
    .ready(ready), .err(err), .done_valid(done_valid), .done_op(done_op), .done_err(done_err),
    .busy(busy), .fifo_count(fifo_count), .err_count(err_count)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int cyc = 0, starts = 0, dones = 0;
  logic [3:0]  st_op[$];
  logic [31:0] st_data[$];
  int          st_cyc[$];
  logic        hold;
  int          resp_delay;
  logic [2:0]  resp_err;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (C_start) begin
      starts++;
      st_op.push_back(C_op);
      st_data.push_back(C_data);
      st_cyc.push_back(cyc);
    end
    if (done_valid) dones++;
  end

  // bid controller model: drops ready on a strobe, answers resp_delay cycles later
  initial begin
    ready = 1;
    err = 0;
    forever begin
      @(negedge clk);
      if (hold) ready = 0;
      else if (C_start) begin
        ready = 0;
        repeat (resp_delay) @(negedge clk);
        err = resp_err;
        ready = 1;
      end else ready = 1;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic push(input logic [3:0] op, input logic [31:0] d, output logic acc);
    @(negedge clk);
    cmd_valid = 1;
    cmd_op = op;
    cmd_data = d;
    acc = cmd_ready;
    @(posedge clk);
    #1 cmd_valid = 0;
  endtask

  task automatic wait_start(input string tag);
    for (int i = 0; i < 40 && !C_start; i++) @(negedge clk);
    check(tag, C_start, 1);
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 40 && !done_valid; i++) @(negedge clk);
    check(tag, done_valid, 1);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_cmd_ready"}, cmd_ready, 1);
    check({tag, "_fifo_count"}, fifo_count, 0);
    check({tag, "_err_count"}, err_count, 0);
    check({tag, "_C_start"}, C_start, 0);
    check({tag, "_C_op"}, C_op, 0);
    check({tag, "_C_data"}, C_data, 0);
    check({tag, "_done_valid"}, done_valid, 0);
    check({tag, "_done_op"}, done_op, 0);
    check({tag, "_done_err"}, done_err, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    logic acc;
    logic [4:0] accs;
    int s, d;
    hold = 0; resp_delay = 3; resp_err = 0;
    reset_n = 0; cmd_valid = 0; cmd_op = 0; cmd_data = 0;
    repeat (2) @(negedge clk);
    check_reset("por");
    // single command, pushed on the first edge out of reset
    @(negedge clk);
    reset_n = 1;
    cmd_valid = 1; cmd_op = 4'd1; cmd_data = 32'h0000_1234;
    @(posedge clk);
    #1 cmd_valid = 0;
    check("first_push_count", fifo_count, 1);
    @(negedge clk) check("lat_e0", C_start, 0);
    @(negedge clk) check("lat_e1", C_start, 0);
    @(negedge clk) check("lat_e2", C_start, 1);
    check("single_C_op", C_op, 1);
    check("single_C_data", C_data, 32'h1234);
    wait_done("single_done");
    check("single_done_op", done_op, 1);
    check("single_done_err", done_err, 0);
    @(negedge clk);
    check("single_pulse_len", done_valid, 0);
    check("single_op_hold", done_op, 1);
    check("single_err_count", err_count, 0);
    #1 check("single_starts", starts, 1);
    check("single_dones", dones, 1);
    // fill the FIFO while the controller is busy
    hold = 1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      push(4'(i + 2), 32'hA0 + i, acc);
      accs[i] = acc;
    end
    check("full_accepts", accs, 5'b01111);
    @(negedge clk);
    check("full_count", fifo_count, 4);
    check("full_cmd_ready", cmd_ready, 0);
    check("full_busy", busy, 1);
    repeat (3) @(negedge clk);
    #1 check("full_no_start", starts, 1);
    s = starts;
    hold = 0;
    wait_start("drain_start");
    check("drain_first_op", C_op, 2);
    // full FIFO refuses a push even while popping
    cmd_valid = 1; cmd_op = 4'd7; cmd_data = 32'h77;
    check("full_pop_refuse", cmd_ready, 0);
    @(posedge clk);
    #1 cmd_valid = 0;
    check("pop_count", fifo_count, 3);
    push(4'd8, 32'h88, acc);
    check("refill_accept", acc, 1);
    repeat (40) @(negedge clk);
    #1 check("drain_starts", starts - s, 5);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("drain_op%0d", i), st_op[s + i], i + 2);
      check($sformatf("drain_data%0d", i), st_data[s + i], 32'hA0 + i);
    end
    check("drain_op4", st_op[s + 4], 8);
    check("drain_data4", st_data[s + 4], 32'h88);
    check("drain_spacing", st_cyc[s + 1] - st_cyc[s], 6);
    check("drain_empty", fifo_count, 0);
    check("drain_idle", busy, 0);
    // controller reports BADKEY
    resp_err = 3'd1;
    push(4'd3, 32'h33, acc);
    wait_done("err_done");
    check("err_done_op", done_op, 3);
    check("err_done_err", done_err, 1);
    @(negedge clk) check("err_count_1", err_count, 1);
    // controller never answers: timeout after 8 WAIT cycles
    resp_err = 3'd0;
    resp_delay = 20;
    push(4'd9, 32'h99, acc);
    @(negedge clk);
    wait_start("to_start");
    check("to_C_op", C_op, 9);
    repeat (8) @(negedge clk);
    check("to_not_early", done_valid, 0);
    @(negedge clk);
    check("to_done", done_valid, 1);
    check("to_done_err", done_err, 7);
    check("to_done_op", done_op, 9);
    @(negedge clk) check("to_err_count", err_count, 2);
    repeat (15) @(negedge clk);
    check("to_err_hold", done_err, 7);
    // reset in WAIT with two commands queued
    #1 s = starts;
    d = dones;
    push(4'd1, 32'h1, acc);
    push(4'd2, 32'h2, acc);
    push(4'd3, 32'h3, acc);
    @(negedge clk);
    wait_start("rst_start");
    repeat (2) @(negedge clk);
    check("rst_queued", fifo_count, 2);
    #1 reset_n = 0;
    #1 check_reset("mid");
    @(negedge clk) reset_n = 1;
    repeat (20) @(negedge clk);
    #1 check("rst_starts", starts - s, 1);
    check("rst_dones", dones - d, 0);
    check("rst_count", fifo_count, 0);
    check("rst_busy", busy, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
